// File: rtl/deser_word_align.sv
// ---------------------------------------------------------------------------
// deser_word_align
//   Word aligner behind the single-lane deserializer. It searches bit offsets
//   0..WORD_SIZE-1 across two consecutive raw words until the ADC sync
//   pattern shows up MATCH_CNT times in a row, then locks that offset and
//   streams word-aligned data to the readout path.
//
//   State table:
//     ST_IDLE   | waiting for train_start, slip parked
//     ST_SETTLE | discarding SETTLE_WORDS words after a slip change
//     ST_CHECK  | comparing each window against SYNC_PATTERN
//     ST_LOCKED | offset found; slip frozen, mismatches ignored
//     ST_FAIL   | every offset tried without lock; waits for train_start
//
// Ports
//   clk            fabric word clock
//   rst            asynchronous, active-high reset
//   word_in        raw word from the deserializer
//   word_valid     1-cycle strobe, word_in holds a new word
//   train_start    1-cycle pulse, restart alignment from offset 0
//   aligned_data   slipped word, registered (1-clk latency)
//   aligned_valid  strobe qualifying aligned_data, only while locked
//   slip_offset    current slip offset
//   busy           training in progress (SETTLE or CHECK)
//   locked         alignment found, sticky until train_start or rst
//   train_fail     all offsets tried, sticky until train_start or rst
// ---------------------------------------------------------------------------
module deser_word_align #(
    parameter int                   WORD_SIZE    = 24,
    parameter logic [WORD_SIZE-1:0] SYNC_PATTERN = 24'hFFF000,
    parameter int                   MATCH_CNT    = 4,
    parameter int                   SETTLE_WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] word_in,
    input  logic                 word_valid,
    input  logic                 train_start,
    output logic [WORD_SIZE-1:0] aligned_data,
    output logic                 aligned_valid,
    output logic [4:0]           slip_offset,
    output logic                 busy,
    output logic                 locked,
    output logic                 train_fail
);

    localparam int MCW = $clog2(MATCH_CNT + 1);
    localparam int SCW = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS + 1) : 1;
    localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_CNT - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_WORDS > 0) ? SETTLE_WORDS - 1 : 0);
    localparam logic [4:0]     SLIP_LAST   = 5'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] prev_word;
    logic [4:0]           slip;
    logic [SCW-1:0]       settle_cnt;
    logic [MCW-1:0]       match_cnt;
    logic [2*WORD_SIZE-1:0] cat;
    logic [WORD_SIZE-1:0] window;

    // Older word sits in the MSBs; slip k takes the window starting k bits
    // below the top, so the tail of the window comes from the newer word.
    assign cat    = {prev_word, word_in};
    assign window = WORD_SIZE'((cat << slip) >> WORD_SIZE);

    assign slip_offset = slip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            prev_word     <= '0;
            slip          <= '0;
            settle_cnt    <= '0;
            match_cnt     <= '0;
            aligned_data  <= '0;
            aligned_valid <= 1'b0;
            busy          <= 1'b0;
            locked        <= 1'b0;
            train_fail    <= 1'b0;
        end else begin
            if (word_valid) begin
                prev_word    <= word_in;
                aligned_data <= window;
            end
            aligned_valid <= word_valid & locked;

            // train_start wins over any word arriving in the same cycle;
            // that word still updates prev_word but is never checked.
            if (train_start) begin
                state      <= ST_SETTLE;
                slip       <= '0;
                settle_cnt <= '0;
                match_cnt  <= '0;
                busy       <= 1'b1;
                locked     <= 1'b0;
                train_fail <= 1'b0;
            end else begin
                case (state)
                    ST_SETTLE: begin
                        if (SETTLE_WORDS == 0) begin
                            state     <= ST_CHECK;
                            match_cnt <= '0;
                        end else if (word_valid) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                state     <= ST_CHECK;
                                match_cnt <= '0;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (word_valid) begin
                            if (window == SYNC_PATTERN) begin
                                if (match_cnt == MATCH_LAST) begin
                                    state  <= ST_LOCKED;
                                    busy   <= 1'b0;
                                    locked <= 1'b1;
                                end else begin
                                    match_cnt <= match_cnt + 1'b1;
                                end
                            end else if (slip != SLIP_LAST) begin
                                slip       <= slip + 1'b1;
                                settle_cnt <= '0;
                                state      <= ST_SETTLE;
                            end else begin
                                // last offset exhausted: park at WORD_SIZE-1, no wrap
                                state      <= ST_FAIL;
                                busy       <= 1'b0;
                                train_fail <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE, LOCKED and FAIL only leave on train_start
                    end
                endcase
            end
        end
    end

endmodule
